// File: rtl/counter_cmp_load_if.sv
// Control/status bundle for the loadable compare counter.
// Master drives the controls, slave (the counter) drives the status.
interface counter_cmp_load_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] data;
  logic             cmp_we;
  logic [WIDTH-1:0] cmp_data;
  logic             clr_wraps;
  logic [WIDTH-1:0] count;
  logic             match;
  logic             tc;
  logic             done;
  logic [CNT_W-1:0] wrap_cnt;

  modport master (
    output en, up, load, data,
    output cmp_we, cmp_data, clr_wraps,
    input  count, match, tc, done, wrap_cnt
  );

  modport slave (
    input  en, up, load, data,
    input  cmp_we, cmp_data, clr_wraps,
    output count, match, tc, done, wrap_cnt
  );
endinterface

// File: rtl/counter_cmp_load.sv
// Loadable up/down counter with compare register, wrap or
// one-shot terminal handling, tc pulse and saturating wrap count.
module counter_cmp_load #(
  parameter int WIDTH   = 4,
  parameter int CNT_W   = 8,
  parameter int ONESHOT = 0
) (
  input logic              clk,
  input logic              rst,
  counter_cmp_load_if.slave bus
);
  localparam bit ONE = (ONESHOT != 0);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] cmp_q, cmp_d;
  logic             tc_q, tc_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] wrap_q, wrap_d;
  logic             run;
  logic             term;

  always_comb begin
    run  = bus.en & ~done_q & ~bus.load;
    term = run & (bus.up ? (count_q >= cmp_q)
                         : (count_q == '0));
  end

  always_comb begin
    count_d = count_q;
    done_d  = done_q;
    tc_d    = term;
    cmp_d   = bus.cmp_we ? bus.cmp_data : cmp_q;
    wrap_d  = wrap_q;
    if (bus.load) begin
      count_d = bus.data;
      done_d  = 1'b0;
    end else if (term) begin
      // one-shot parks at the terminal value
      if (ONE) begin
        done_d = 1'b1;
      end else begin
        count_d = bus.up ? '0 : cmp_q;
      end
    end else if (run) begin
      count_d = bus.up ? count_q + WIDTH'(1)
                       : count_q - WIDTH'(1);
    end
    if (bus.clr_wraps) begin
      wrap_d = '0;
    end else if (term && wrap_q != '1) begin
      wrap_d = wrap_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      cmp_q   <= '1;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= '0;
    end else begin
      count_q <= count_d;
      cmp_q   <= cmp_d;
      tc_q    <= tc_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.count    = count_q;
  assign bus.match    = (count_q == cmp_q);
  assign bus.tc       = tc_q;
  assign bus.done     = done_q;
  assign bus.wrap_cnt = wrap_q;
endmodule

// File: tb/tb_counter_cmp_load.sv
// Bench: wrap-mode (CNT_W=2) and one-shot instances share stimulus,
// checked by directed tables, hand sequences and a reference model.
module tb_counter_cmp_load;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  counter_cmp_load_if #(.WIDTH(4), .CNT_W(2)) ifa ();
  counter_cmp_load_if #(.WIDTH(4), .CNT_W(8)) ifb ();

  counter_cmp_load #(.WIDTH(4), .CNT_W(2), .ONESHOT(0)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa)
  );
  counter_cmp_load #(.WIDTH(4), .CNT_W(8), .ONESHOT(1)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb)
  );

  typedef struct {
    int rst; int en; int up; int ld; int d;
    int we; int cd; int clr;
  } ins_t;

  typedef struct {
    int cnt; int tc; int wr; int m;
  } exp_t;

  typedef struct {
    ins_t i;
    exp_t e;
  } vec_t;

  typedef struct {
    int cnt; int cmp; int tc; int done; int wr;
  } mst_t;

  int   total = 0;
  int   bad = 0;
  ins_t cur;
  mst_t ma, mb;
  vec_t tbl[$];

  function automatic mst_t step(mst_t s, bit os,
                                int wmax, ins_t x);
    mst_t n;
    bit   t;
    n = s;
    t = 1'b0;
    n.tc = 0;
    if (x.rst != 0) begin
      n.cnt = 0; n.cmp = 15; n.done = 0; n.wr = 0;
      return n;
    end
    if (x.ld != 0) begin
      n.cnt = x.d;
      n.done = 0;
    end else if (x.en != 0 && s.done == 0) begin
      if (x.up != 0) begin
        if (s.cnt >= s.cmp) t = 1'b1;
        else n.cnt = (s.cnt + 1) % 16;
      end else begin
        if (s.cnt == 0) t = 1'b1;
        else n.cnt = s.cnt - 1;
      end
      if (t) begin
        n.tc = 1;
        if (os) n.done = 1;
        else n.cnt = (x.up != 0) ? 0 : s.cmp;
      end
    end
    if (x.we != 0) n.cmp = x.cd;
    if (x.clr != 0) n.wr = 0;
    else if (t && s.wr < wmax) n.wr = s.wr + 1;
    return n;
  endfunction

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s t=%0t act=%0d exp=%0d",
               nm, $time, act, exp);
    end
  endtask

  task automatic drive();
    rst           = cur.rst[0];
    ifa.en        = cur.en[0];
    ifa.up        = cur.up[0];
    ifa.load      = cur.ld[0];
    ifa.data      = 4'(cur.d);
    ifa.cmp_we    = cur.we[0];
    ifa.cmp_data  = 4'(cur.cd);
    ifa.clr_wraps = cur.clr[0];
    ifb.en        = cur.en[0];
    ifb.up        = cur.up[0];
    ifb.load      = cur.ld[0];
    ifb.data      = 4'(cur.d);
    ifb.cmp_we    = cur.we[0];
    ifb.cmp_data  = 4'(cur.cd);
    ifb.clr_wraps = cur.clr[0];
  endtask

  task automatic check_model();
    chk("a_count", int'(ifa.count), ma.cnt);
    chk("a_tc",    int'(ifa.tc), ma.tc);
    chk("a_done",  int'(ifa.done), ma.done);
    chk("a_wraps", int'(ifa.wrap_cnt), ma.wr);
    chk("a_match", int'(ifa.match),
        int'(ma.cnt == ma.cmp));
    chk("b_count", int'(ifb.count), mb.cnt);
    chk("b_tc",    int'(ifb.tc), mb.tc);
    chk("b_done",  int'(ifb.done), mb.done);
    chk("b_wraps", int'(ifb.wrap_cnt), mb.wr);
    chk("b_match", int'(ifb.match),
        int'(mb.cnt == mb.cmp));
  endtask

  task automatic tick();
    drive();
    @(posedge clk);
    ma = step(ma, 1'b0, 3, cur);
    mb = step(mb, 1'b1, 255, cur);
    #1;
    check_model();
  endtask

  task automatic set(int r, int en, int up, int ld,
                     int d, int we, int cd, int clr);
    cur = '{r, en, up, ld, d, we, cd, clr};
  endtask

  task automatic add(int r, int en, int up, int ld,
                     int d, int we, int cd, int clr,
                     int c, int t, int w, int m);
    vec_t v;
    v.i = '{r, en, up, ld, d, we, cd, clr};
    v.e = '{c, t, w, m};
    tbl.push_back(v);
  endtask

  initial begin
    ma = '{0, 15, 0, 0, 0};
    mb = '{0, 15, 0, 0, 0};
    set(1, 0, 0, 0, 0, 0, 0, 0);
    drive();

    // wrap up-count to 5
    add(1,0,0,0,0,0,0,0, 0,0,0,0);
    add(0,0,0,0,0,1,5,0, 0,0,0,0);
    add(0,1,1,0,0,0,0,0, 1,0,0,0);
    add(0,1,1,0,0,0,0,0, 2,0,0,0);
    add(0,1,1,0,0,0,0,0, 3,0,0,0);
    add(0,1,1,0,0,0,0,0, 4,0,0,0);
    add(0,1,1,0,0,0,0,0, 5,0,0,1);
    add(0,1,1,0,0,0,0,0, 0,1,1,0);
    add(0,1,1,0,0,0,0,0, 1,0,1,0);
    // down from 2 with cmp 3
    add(0,0,0,1,2,1,3,0, 2,0,1,0);
    add(0,1,0,0,0,0,0,0, 1,0,1,0);
    add(0,1,0,0,0,0,0,0, 0,0,1,0);
    add(0,1,0,0,0,0,0,0, 3,1,2,1);
    add(0,1,0,0,0,0,0,0, 2,0,2,0);
    // cmp write on same edge uses old cmp
    add(0,0,0,1,9,1,15,0, 9,0,2,0);
    add(0,1,1,0,0,1,4,0, 10,0,2,0);
    add(0,1,1,0,0,0,0,0, 0,1,3,0);
    add(0,1,1,0,0,0,0,0, 1,0,3,0);
    // cmp=0, saturation, clear, reset
    add(0,0,0,0,0,0,0,1, 1,0,0,0);
    add(0,0,0,1,0,1,0,0, 0,0,0,1);
    add(0,1,1,0,0,0,0,0, 0,1,1,1);
    add(0,1,1,0,0,0,0,0, 0,1,2,1);
    add(0,1,1,0,0,0,0,0, 0,1,3,1);
    add(0,1,1,0,0,0,0,0, 0,1,3,1);
    add(0,1,1,0,0,0,0,1, 0,1,0,1);
    add(1,1,1,0,0,0,0,0, 0,0,0,0);

    foreach (tbl[k]) begin
      cur = tbl[k].i;
      tick();
      chk($sformatf("v%0d_count", k),
          int'(ifa.count), tbl[k].e.cnt);
      chk($sformatf("v%0d_tc", k),
          int'(ifa.tc), tbl[k].e.tc);
      chk($sformatf("v%0d_wraps", k),
          int'(ifa.wrap_cnt), tbl[k].e.wr);
      chk($sformatf("v%0d_match", k),
          int'(ifa.match), tbl[k].e.m);
    end

    // one-shot stops at 3, load restarts
    set(0, 0, 0, 0, 0, 1, 3, 0); tick();
    set(0, 1, 1, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("os_count", int'(ifb.count), k);
      chk("os_done", int'(ifb.done), 0);
    end
    tick();
    chk("os_hold", int'(ifb.count), 3);
    chk("os_done1", int'(ifb.done), 1);
    chk("os_tc1", int'(ifb.tc), 1);
    tick();
    chk("os_hold2", int'(ifb.count), 3);
    chk("os_tc0", int'(ifb.tc), 0);
    chk("os_done2", int'(ifb.done), 1);
    set(0, 1, 1, 1, 0, 0, 0, 0); tick();
    chk("os_ld_done", int'(ifb.done), 0);
    chk("os_ld_cnt", int'(ifb.count), 0);
    set(0, 1, 1, 0, 0, 0, 0, 0); tick();
    chk("os_resume", int'(ifb.count), 1);

    // random stimulus against the model
    for (int k = 0; k < 400; k++) begin
      cur.rst = int'($urandom_range(39) == 0);
      cur.en  = int'($urandom_range(3) != 0);
      cur.up  = int'($urandom_range(1));
      cur.ld  = int'($urandom_range(11) == 0);
      cur.d   = int'($urandom_range(15));
      cur.we  = int'($urandom_range(9) == 0);
      cur.cd  = int'($urandom_range(15));
      cur.clr = int'($urandom_range(24) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
